vram_arbiter: RTL and testbench
===============================

VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 Parameter BA_TIMEOUT, default 15: WAIT_BA cycles without cpu_ba before err[0] sets.
REQ-002 clk  in  1  system clock; all state updates on rising edge.
REQ-003 rst  in  1  asynchronous, active-low reset.
REQ-004 dma_hold  in  1  VPU bus request, held for the whole DMA burst.
REQ-005 dma_cs  in  1  VPU read strobe for video RAM.
REQ-006 dma_addr  in  16  VPU DMA read address.
REQ-007 dma_data  out  8  registered read data returned to the VPU.
REQ-008 cpu_addr  in  16  CPU address.
REQ-009 cpu_di  in  8  CPU write data.
REQ-010 cpu_rw  in  1  CPU direction: 1 = read, 0 = write.
REQ-011 cpu_vma  in  1  CPU valid memory access.
REQ-012 cpu_ba  in  1  CPU bus-available acknowledge.
REQ-013 cpu_halt  out  1  registered halt request to the CPU.
REQ-014 mem_addr  out  16  memory address.
REQ-015 mem_ce  out  1  memory chip enable.
REQ-016 mem_we  out  1  memory write enable.
REQ-017 mem_dout  out  8  memory write data; always equals cpu_di.
REQ-018 mem_din  in  8  memory read data; synchronous, valid one clock after the mem_ce edge.
REQ-019 err  out  2  sticky flags: [0] BA timeout, [1] dma_cs outside GRANT.
REQ-020 err_clr  in  1  clears err.
REQ-021 steal_cnt  out  16  count of DMA read cycles performed.
REQ-022 stat_clr  in  1  clears steal_cnt.

Function
REQ-023 The block SHALL have four states: IDLE, WAIT_BA, GRANT and RELEASE, with a one-hot or binary encoding and no other reachable states.
REQ-024 In IDLE with dma_hold=1, the block SHALL move to WAIT_BA and set cpu_halt=1 on the same edge.
REQ-025 In WAIT_BA, priority is:
- dma_hold=0: go to RELEASE, even if cpu_ba=1 in the same cycle.
- else cpu_ba=1: go to GRANT.
- else: stay in WAIT_BA.
REQ-026 In GRANT with dma_hold=0, the block SHALL go to RELEASE; otherwise it stays in GRANT.
REQ-027 cpu_halt SHALL be 1 in WAIT_BA and GRANT and 0 in IDLE and RELEASE, registered, changing on the edge that enters or leaves those states.
REQ-028 RELEASE SHALL last exactly one cycle and then go to IDLE; mem_ce SHALL be 0 throughout RELEASE.
REQ-029 Outside GRANT and RELEASE, memory outputs follow the CPU:
- mem_addr = cpu_addr
- mem_ce = cpu_vma
- mem_we = cpu_vma & ~cpu_rw
REQ-030 In GRANT, memory outputs follow the VPU: mem_addr = dma_addr, mem_ce = dma_cs, mem_we = 0.
REQ-031 The memory-side outputs SHALL be a combinational mux of the registered state only, with no other logic.
REQ-032 dma_data SHALL load mem_din on the clock after every GRANT cycle with dma_cs=1, and otherwise hold its value.
REQ-033 Read latency from the dma_addr/dma_cs cycle to dma_data valid SHALL be 2 clocks.
REQ-034 A 4-bit wait counter SHALL clear on entering WAIT_BA and increment each WAIT_BA cycle, saturating at 15.
REQ-035 When the wait counter equals BA_TIMEOUT, err[0] SHALL set; the state stays WAIT_BA and the request is not dropped.
REQ-036 err[1] SHALL set on any cycle with dma_cs=1 while state is not GRANT; the memory ignores that strobe.
REQ-037 err_clr SHALL clear both err bits; if a set condition occurs in the same cycle, set wins.
REQ-038 steal_cnt SHALL increment once per GRANT cycle with dma_cs=1, saturating at 16'hFFFF.
REQ-039 stat_clr SHALL clear steal_cnt; if an increment occurs in the same cycle, clear wins.
REQ-040 A CPU write in progress during WAIT_BA SHALL complete unaltered, since the CPU still owns the memory bus there.

Reset
REQ-041 When rst=0, asynchronously: state=IDLE, cpu_halt=0, dma_data=0, err=0, steal_cnt=0, wait counter=0.
REQ-042 While in reset, mem_* outputs SHALL follow the CPU mapping.
REQ-043 Reset asserted in GRANT SHALL immediately return the bus to the CPU and drop cpu_halt.
REQ-044 After rst deasserts, the block SHALL accept a new dma_hold no earlier than the first rising edge.

Verification
REQ-045 Basic burst: dma_hold=1, cpu_ba=1 two cycles later, then 4 dma_cs reads of mem bytes 11,22,33,44 -> cpu_halt=1 one edge after hold; dma_data shows 11..44 each 2 clocks after its strobe; steal_cnt=4.
REQ-046 BA timeout: dma_hold=1, cpu_ba held 0 for 20 cycles -> err=01 after 15 WAIT_BA cycles; state stays WAIT_BA; cpu_ba=1 then gives GRANT.
REQ-047 Early strobe: dma_cs=1 in IDLE -> err=10; mem_ce follows cpu_vma; the same-cycle err_clr test leaves err=10.
REQ-048 Release race: dma_hold drops in the same cycle as cpu_ba rises -> RELEASE then IDLE; no GRANT; cpu_halt=0 after 1 edge.
REQ-049 Mid-grant reset: rst=0 during GRANT -> cpu_halt=0 and steal_cnt=0 immediately; mem_addr=cpu_addr.
REQ-050 Saturation/clear: preload 65535 reads, then one more read with stat_clr asserted in the same cycle -> steal_cnt=0.

Source files
------------

// File: rtl/vram_arbiter.sv
// vram_arbiter
//   Shares one synchronous video RAM between a CPU and a VPU DMA engine.
//   The VPU requests the bus with dma_hold; the CPU is halted and, once it
//   acknowledges with cpu_ba, the VPU owns the memory port until dma_hold
//   drops. One dead RELEASE cycle separates VPU ownership from the CPU.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   IDLE    | CPU owns the memory bus, no DMA request pending
//   WAIT_BA | cpu_halt raised, waiting for cpu_ba; CPU still owns bus
//   GRANT   | VPU owns the memory bus (dma_addr/dma_cs drive memory)
//   RELEASE | one-cycle turnaround, memory deselected, halt dropped
//
// Ports
//   clk, rst             clock, async active-low reset
//   dma_hold/cs/addr     VPU bus request, read strobe, read address
//   dma_data             registered read data back to the VPU
//   cpu_addr/di/rw/vma   CPU bus cycle (rw: 1 = read)
//   cpu_ba, cpu_halt     CPU bus-available ack / halt request
//   mem_addr/ce/we/dout  memory port; mem_din is synchronous read data
//   err, err_clr         sticky flags [0] BA timeout, [1] stray dma_cs
//   steal_cnt, stat_clr  saturating count of DMA read cycles

module vram_arbiter #(
   parameter int unsigned BA_TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        dma_hold,
   input  logic        dma_cs,
   input  logic [15:0] dma_addr,
   output logic [7:0]  dma_data,
   input  logic [15:0] cpu_addr,
   input  logic [7:0]  cpu_di,
   input  logic        cpu_rw,
   input  logic        cpu_vma,
   input  logic        cpu_ba,
   output logic        cpu_halt,
   output logic [15:0] mem_addr,
   output logic        mem_ce,
   output logic        mem_we,
   output logic [7:0]  mem_dout,
   input  logic [7:0]  mem_din,
   output logic [1:0]  err,
   input  logic        err_clr,
   output logic [15:0] steal_cnt,
   input  logic        stat_clr
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WAIT_BA = 2'd1,
      GRANT   = 2'd2,
      RELEASE = 2'd3
   } state_t;

   localparam logic [3:0] TIMEOUT = 4'(BA_TIMEOUT);

   state_t      state;
   state_t      state_nxt;
   logic        halt_nxt;
   logic [3:0]  wait_cnt;
   logic [3:0]  wait_inc;
   logic        grant_rd;
   logic        rd_pend;
   logic [1:0]  err_set;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         cpu_halt <= 1'b0;
      end else begin
         state    <= state_nxt;
         cpu_halt <= halt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (dma_hold) state_nxt = WAIT_BA;
         WAIT_BA: begin
            // a dropped request beats a late bus-available ack
            if (!dma_hold)   state_nxt = RELEASE;
            else if (cpu_ba) state_nxt = GRANT;
         end
         GRANT:   if (!dma_hold) state_nxt = RELEASE;
         RELEASE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      halt_nxt = (state_nxt == WAIT_BA) || (state_nxt == GRANT);
   end

   // Memory port is steered by the registered state alone.
   always_comb begin
      mem_addr = cpu_addr;
      mem_ce   = cpu_vma;
      mem_we   = cpu_vma & ~cpu_rw;
      case (state)
         GRANT: begin
            mem_addr = dma_addr;
            mem_ce   = dma_cs;
            mem_we   = 1'b0;
         end
         RELEASE: begin
            mem_ce = 1'b0;
            mem_we = 1'b0;
         end
         default: ;
      endcase
   end

   assign mem_dout = cpu_di;

   assign wait_inc = (wait_cnt == 4'hF) ? wait_cnt : wait_cnt + 4'd1;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wait_cnt <= 4'd0;
      end else if (state != WAIT_BA && state_nxt == WAIT_BA) begin
         wait_cnt <= 4'd0;
      end else if (state == WAIT_BA) begin
         wait_cnt <= wait_inc;
      end
   end

   // err[0] rises on the same edge the counter reaches the timeout value
   assign err_set[0] = (state == WAIT_BA) && (wait_inc == TIMEOUT);
   assign err_set[1] = dma_cs && (state != GRANT);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         err <= 2'b00;
      end else begin
         err <= err_set | (err & {2{~err_clr}});
      end
   end

   assign grant_rd = (state == GRANT) && dma_cs;

   // mem_din is valid one clock after the strobe edge, so the capture is
   // delayed by one pipeline flag: two clocks strobe-to-dma_data.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_pend  <= 1'b0;
         dma_data <= 8'h00;
      end else begin
         rd_pend <= grant_rd;
         if (rd_pend) dma_data <= mem_din;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         steal_cnt <= 16'h0000;
      end else if (stat_clr) begin
         steal_cnt <= 16'h0000;
      end else if (grant_rd && steal_cnt != 16'hFFFF) begin
         steal_cnt <= steal_cnt + 16'd1;
      end
   end

endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter
//   Directed bench for vram_arbiter with a small synchronous RAM model.

module tb_vram_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        dma_hold, dma_cs, cpu_rw, cpu_vma, cpu_ba, err_clr, stat_clr;
   logic [15:0] dma_addr, cpu_addr, mem_addr, steal_cnt;
   logic [7:0]  dma_data, cpu_di, mem_dout, mem_din;
   logic        cpu_halt, mem_ce, mem_we;
   logic [1:0]  err;

   int nvec = 0;
   int nerr = 0;

   logic [7:0] ram [0:255];
   logic [7:0] burst [4];

   vram_arbiter #(.BA_TIMEOUT(15)) dut (
      .clk(clk), .rst(rst),
      .dma_hold(dma_hold), .dma_cs(dma_cs), .dma_addr(dma_addr), .dma_data(dma_data),
      .cpu_addr(cpu_addr), .cpu_di(cpu_di), .cpu_rw(cpu_rw), .cpu_vma(cpu_vma),
      .cpu_ba(cpu_ba), .cpu_halt(cpu_halt),
      .mem_addr(mem_addr), .mem_ce(mem_ce), .mem_we(mem_we), .mem_dout(mem_dout),
      .mem_din(mem_din),
      .err(err), .err_clr(err_clr), .steal_cnt(steal_cnt), .stat_clr(stat_clr)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_ce) begin
         if (mem_we) ram[mem_addr[7:0]] <= mem_dout;
         else        mem_din <= ram[mem_addr[7:0]];
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) ram[i] = 8'h00;
      ram[8'h40] = 8'h11; ram[8'h41] = 8'h22; ram[8'h42] = 8'h33; ram[8'h43] = 8'h44;
      burst[0] = 8'h11; burst[1] = 8'h22; burst[2] = 8'h33; burst[3] = 8'h44;
      mem_din  = 8'h00;
      dma_hold = 0; dma_cs = 0; dma_addr = 16'h0000;
      cpu_addr = 16'h1234; cpu_di = 8'h00; cpu_rw = 1; cpu_vma = 1; cpu_ba = 0;
      err_clr = 0; stat_clr = 0;
      rst = 1;
      #1 rst = 0;
      #1;
      // reset state and CPU mapping during reset
      chk("rst_halt", cpu_halt, 0);
      chk("rst_dma_data", dma_data, 0);
      chk("rst_err", err, 0);
      chk("rst_steal", steal_cnt, 0);
      chk("rst_mem_addr", mem_addr, 16'h1234);
      chk("rst_mem_ce", mem_ce, 1);
      chk("rst_mem_we_rd", mem_we, 0);
      cpu_rw = 0; #1;
      chk("rst_mem_we_wr", mem_we, 1);
      cpu_rw = 1; cpu_vma = 0;
      @(negedge clk) rst = 1;
      tick();
      chk("idle_halt", cpu_halt, 0);

      // basic burst with a CPU write completing during WAIT_BA
      dma_hold = 1;
      tick();
      chk("burst_halt_1edge", cpu_halt, 1);
      cpu_vma = 1; cpu_rw = 0; cpu_addr = 16'h0080; cpu_di = 8'h5A;
      #1;
      chk("wait_cpu_addr", mem_addr, 16'h0080);
      chk("wait_cpu_we", mem_we, 1);
      chk("wait_cpu_ce", mem_ce, 1);
      chk("wait_cpu_dout", mem_dout, 8'h5A);
      tick();
      cpu_vma = 0; cpu_rw = 1; cpu_ba = 1;
      tick();
      chk("grant_halt", cpu_halt, 1);
      for (int i = 0; i < 4; i++) begin
         dma_addr = 16'h0040 + 16'(i); dma_cs = 1;
         #1;
         if (i == 0) begin
            chk("grant_mem_addr", mem_addr, 16'h0040);
            chk("grant_mem_ce", mem_ce, 1);
            chk("grant_mem_we", mem_we, 0);
         end
         tick();
         chk("burst_data", dma_data, (i == 0) ? 8'h00 : burst[i-1]);
      end
      dma_cs = 0;
      #1;
      chk("grant_ce_idle_strobe", mem_ce, 0);
      tick();
      chk("burst_data_last", dma_data, 8'h44);
      chk("burst_steal", steal_cnt, 4);
      tick();
      chk("burst_data_hold", dma_data, 8'h44);
      dma_addr = 16'h0080; dma_cs = 1;
      tick();
      dma_cs = 0;
      tick();
      chk("cpu_write_readback", dma_data, 8'h5A);
      chk("steal_5", steal_cnt, 5);
      dma_hold = 0; cpu_ba = 0;
      tick();
      chk("release_halt", cpu_halt, 0);
      cpu_vma = 1; #1;
      chk("release_ce", mem_ce, 0);
      tick();
      chk("idle_ce", mem_ce, 1);
      chk("burst_err", err, 0);
      cpu_vma = 0;

      // BA timeout
      cpu_addr = 16'h1234;
      dma_hold = 1;
      tick();
      tick(14);
      chk("timeout_14", err, 2'b00);
      tick();
      chk("timeout_15", err, 2'b01);
      tick(5);
      chk("timeout_halt", cpu_halt, 1);
      chk("timeout_err_sticky", err, 2'b01);
      dma_addr = 16'h0041;
      #1;
      chk("timeout_still_wait", mem_addr, 16'h1234);
      cpu_ba = 1;
      tick();
      chk("timeout_then_grant", mem_addr, 16'h0041);
      err_clr = 1;
      tick();
      chk("err_clr", err, 2'b00);
      err_clr = 0; dma_hold = 0; cpu_ba = 0;
      tick(2);

      // early strobe in IDLE
      dma_cs = 1; cpu_vma = 1; cpu_rw = 1; cpu_addr = 16'h00AA;
      #1;
      chk("early_ce_vma1", mem_ce, 1);
      chk("early_addr", mem_addr, 16'h00AA);
      cpu_vma = 0; #1;
      chk("early_ce_vma0", mem_ce, 0);
      tick();
      chk("early_err", err, 2'b10);
      err_clr = 1;
      tick();
      chk("early_set_wins", err, 2'b10);
      dma_cs = 0;
      tick();
      chk("early_cleared", err, 2'b00);
      err_clr = 0;
      chk("early_steal", steal_cnt, 5);

      // release race
      dma_hold = 1;
      tick(2);
      chk("race_wait_halt", cpu_halt, 1);
      dma_hold = 0; cpu_ba = 1;
      tick();
      chk("race_halt", cpu_halt, 0);
      cpu_vma = 1; #1;
      chk("race_release_ce", mem_ce, 0);
      tick();
      chk("race_idle_ce", mem_ce, 1);
      cpu_ba = 0; cpu_vma = 0;

      // mid-grant reset
      cpu_addr = 16'h4321;
      dma_hold = 1;
      tick();
      cpu_ba = 1;
      tick();
      dma_addr = 16'h0042; dma_cs = 1;
      tick();
      chk("pre_reset_steal", steal_cnt, 6);
      chk("pre_reset_addr", mem_addr, 16'h0042);
      rst = 0;
      #1;
      chk("mid_reset_halt", cpu_halt, 0);
      chk("mid_reset_steal", steal_cnt, 0);
      chk("mid_reset_addr", mem_addr, 16'h4321);
      chk("mid_reset_dma_data", dma_data, 0);
      dma_hold = 0; dma_cs = 0; cpu_ba = 0;
      @(negedge clk) rst = 1;
      tick();

      // saturation and stat_clr priority
      dma_hold = 1;
      tick();
      cpu_ba = 1;
      tick();
      dma_addr = 16'h0040; dma_cs = 1;
      repeat (65535) @(posedge clk);
      #1;
      chk("sat_preload", steal_cnt, 16'hFFFF);
      tick();
      chk("sat_hold", steal_cnt, 16'hFFFF);
      stat_clr = 1;
      tick();
      chk("sat_clr_wins", steal_cnt, 0);
      stat_clr = 0; dma_cs = 0;
      tick();
      chk("sat_after_clr", steal_cnt, 0);
      dma_hold = 0; cpu_ba = 0;
      tick(2);
      chk("end_halt", cpu_halt, 0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
